// File: rtl/dac_tx_pkg.sv
// Shared widths, FSM encoding, DAC power-down codes and 16-bit DAC word assembly
// for the dac_serial_tx transmit stage.
package dac_tx_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 8;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } tx_state_e;

    // DAC word layout: two don't-care zeros, power-down mode, code, four padding zeros.
    function automatic logic [FRAME_W-1:0] build_word(input logic [1:0]        pd,
                                                      input logic [DATA_W-1:0] sample);
        return {2'b00, pd, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_serial_tx_if.sv
// Sample handshake plus three-wire DAC pins of dac_serial_tx; the producer/bench
// side uses the master modport, the transmitter the slave modport.
interface dac_serial_tx_if;
    import dac_tx_pkg::*;

    logic [DATA_W-1:0] sample;
    logic [1:0]        pd;
    logic              valid;
    logic              ready;
    logic              din;
    logic              sync;
    logic              sclk;
    logic              busy;
    logic              frame_done;

    modport master (
        output sample, pd, valid,
        input  ready, din, sync, sclk, busy, frame_done
    );

    modport slave (
        input  sample, pd, valid,
        output ready, din, sync, sclk, busy, frame_done
    );

endinterface

// File: rtl/dac_half_tick.sv
// Loadable down-counter: one-cycle tick_o every load_val_i cycles, reloading itself
// on each tick; serves both the SCLK half-period and the inter-frame gap.
module dac_half_tick #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i || tick_o) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/dac_serial_tx.sv
// Serial transmit stage for an 8-bit SYNC/SCLK/DIN DAC (16-bit frame, MSB first).
// Optional build macro DAC_TX_SKIP_DUP_EN: suppress frames repeating the last {pd,sample}.
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 2
) (
    input logic            clk,
    input logic            rst,
    dac_serial_tx_if.slave bus
);

    localparam int         CNT_MAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int         CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    tx_state_e          state_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [3:0]         bit_q;
    logic               phase_q;
    logic               ready_q, sync_q, sclk_q, din_q, busy_q, frame_done_q;
    logic               tick, dup, start, active;
    logic [CNT_W-1:0]   load_val;

    assign active   = state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD};
    assign start    = bus.valid && ready_q && !dup;
    assign load_val = (state_q == ST_HOLD) ? CNT_W'(GAP_CYC) : CNT_W'(CLK_DIV);

`ifdef DAC_TX_SKIP_DUP_EN
    logic [DATA_W+1:0] last_q;
    logic              last_vld_q;

    assign dup = last_vld_q && (last_q == {bus.pd, bus.sample});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_vld_q <= 1'b0;
            last_q     <= '0;
        end else if (start) begin
            last_vld_q <= 1'b1;
            last_q     <= {bus.pd, bus.sample};
        end
    end
`else
    assign dup = 1'b0;
`endif

    dac_half_tick #(.W(CNT_W)) u_half_tick (
        .clk        (clk),
        .rst        (rst),
        .load_i     (start),
        .load_val_i (load_val),
        .tick_o     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            ready_q      <= 1'b0;
            sync_q       <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout: pins are derived from the pre-edge state_q,
            // so they trail the FSM by exactly one cycle, which the frame timing assumes.
            ready_q      <= (state_q == ST_IDLE) && !start;
            busy_q       <= (state_q != ST_IDLE);
            sync_q       <= !active;
            frame_done_q <= !active && !sync_q;
            sclk_q       <= !((state_q == ST_SHIFT) && !phase_q);
            din_q        <= active && shreg_q[FRAME_W-1];

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETUP;
                        shreg_q <= build_word(bus.pd, bus.sample);
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Leaving a low half is an SCLK rising edge: present the next bit.
                    if (tick) begin
                        if (!phase_q) begin
                            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                            if (bit_q == LAST_BIT) begin
                                state_q <= ST_HOLD;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else begin
                            phase_q <= 1'b0;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (tick) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.din        = din_q;
    assign bus.sync       = sync_q;
    assign bus.sclk       = sclk_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx at default CLK_DIV=2, GAP_CYC=2; edge numbers
// are counted in clk rising edges from the accept edge (edge 0).
module tb_dac_serial_tx;
    import dac_tx_pkg::*;

    typedef struct {
        logic [15:0] word;
        int          nfalls, first_fall, last_fall;
        int          sync_fall, sync_rise, sync_low;
        int          done_edge, done_cnt;
        int          ready_edge, busy_rise, busy_fall;
    } cap_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    dac_serial_tx_if bus_if ();

    dac_serial_tx #(.CLK_DIV(2), .GAP_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for ready, presents one sample for one accept edge, returns #1 after it.
    task automatic do_accept(input logic [7:0] s, input logic [1:0] p, output bit ok);
        int waited = 0;
        while (bus_if.ready !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = (bus_if.ready === 1'b1);
        bus_if.sample = s;
        bus_if.pd     = p;
        bus_if.valid  = 1'b1;
        @(posedge clk); #1;
        bus_if.valid  = 1'b0;
    endtask

    // Records pin events over n edges following an accept edge.
    task automatic capture(input int n, output cap_t c);
        logic p_sclk, p_sync, p_ready, p_busy;
        c.word = '0; c.nfalls = 0; c.first_fall = -1; c.last_fall = -1;
        c.sync_fall = -1; c.sync_rise = -1; c.sync_low = 0;
        c.done_edge = -1; c.done_cnt = 0;
        c.ready_edge = -1; c.busy_rise = -1; c.busy_fall = -1;
        p_sclk = bus_if.sclk; p_sync = bus_if.sync; p_ready = bus_if.ready; p_busy = bus_if.busy;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            if (p_sclk && !bus_if.sclk) begin
                c.word = {c.word[14:0], bus_if.din};
                if (c.nfalls == 0) c.first_fall = e;
                c.last_fall = e;
                c.nfalls++;
            end
            if (p_sync && !bus_if.sync && c.sync_fall < 0) c.sync_fall = e;
            if (!p_sync && bus_if.sync && c.sync_rise < 0) c.sync_rise = e;
            if (!bus_if.sync) c.sync_low++;
            if (bus_if.frame_done) begin c.done_cnt++; c.done_edge = e; end
            if (!p_ready && bus_if.ready && c.ready_edge < 0) c.ready_edge = e;
            if (!p_busy && bus_if.busy && c.busy_rise < 0) c.busy_rise = e;
            if (p_busy && !bus_if.busy && c.busy_fall < 0) c.busy_fall = e;
            p_sclk = bus_if.sclk; p_sync = bus_if.sync; p_ready = bus_if.ready; p_busy = bus_if.busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.valid = 1'b0; bus_if.sample = '0; bus_if.pd = PD_NORMAL;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (bus_if.sync !== 1'b1) $display("FAIL rst_sync: got %b expected 1", bus_if.sync); else pass_cnt++;
        total_cnt++; if (bus_if.sclk !== 1'b1) $display("FAIL rst_sclk: got %b expected 1", bus_if.sclk); else pass_cnt++;
        total_cnt++; if (bus_if.din !== 1'b0) $display("FAIL rst_din: got %b expected 0", bus_if.din); else pass_cnt++;
        total_cnt++; if (bus_if.ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus_if.ready); else pass_cnt++;
        total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus_if.busy); else pass_cnt++;
        total_cnt++; if (bus_if.frame_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus_if.frame_done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (bus_if.ready !== 1'b0) $display("FAIL rel_ready_pre: got %b expected 0", bus_if.ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus_if.ready !== 1'b1) $display("FAIL rel_ready_post: got %b expected 1", bus_if.ready); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        cap_t c;
        bit   ok;
        do_accept(8'hA5, PD_NORMAL, ok);
        total_cnt++; if (!ok) $display("FAIL basic_ready_wait: got 0 expected 1"); else pass_cnt++;
        capture(72, c);
        total_cnt++; if (c.word !== 16'h0A50) $display("FAIL basic_word: got %h expected 0a50", c.word); else pass_cnt++;
        total_cnt++; if (c.nfalls !== 16) $display("FAIL basic_nfalls: got %0d expected 16", c.nfalls); else pass_cnt++;
        total_cnt++; if (c.first_fall !== 3) $display("FAIL basic_first_fall: got %0d expected 3", c.first_fall); else pass_cnt++;
        total_cnt++; if (c.last_fall !== 63) $display("FAIL basic_last_fall: got %0d expected 63", c.last_fall); else pass_cnt++;
        total_cnt++; if (c.sync_fall !== 1) $display("FAIL basic_sync_fall: got %0d expected 1", c.sync_fall); else pass_cnt++;
        total_cnt++; if (c.sync_rise !== 67) $display("FAIL basic_sync_rise: got %0d expected 67", c.sync_rise); else pass_cnt++;
        total_cnt++; if (c.sync_low !== 66) $display("FAIL basic_sync_low: got %0d expected 66", c.sync_low); else pass_cnt++;
        total_cnt++; if (c.done_edge !== 67) $display("FAIL basic_done_edge: got %0d expected 67", c.done_edge); else pass_cnt++;
        total_cnt++; if (c.done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", c.done_cnt); else pass_cnt++;
        total_cnt++; if (c.ready_edge !== 69) $display("FAIL basic_ready_edge: got %0d expected 69", c.ready_edge); else pass_cnt++;
        total_cnt++; if (c.busy_rise !== 1) $display("FAIL basic_busy_rise: got %0d expected 1", c.busy_rise); else pass_cnt++;
        total_cnt++; if (c.busy_fall !== 69) $display("FAIL basic_busy_fall: got %0d expected 69", c.busy_fall); else pass_cnt++;
    endtask

    task automatic test_pd_words();
        cap_t c;
        bit   ok;
        do_accept(8'h3C, PD_HIZ, ok);
        capture(72, c);
        total_cnt++; if (c.word !== 16'h33C0) $display("FAIL pdhiz_word: got %h expected 33c0", c.word); else pass_cnt++;
        total_cnt++; if (c.done_cnt !== 1) $display("FAIL pdhiz_done: got %0d expected 1", c.done_cnt); else pass_cnt++;
        do_accept(8'h01, PD_1K, ok);
        capture(72, c);
        total_cnt++; if (c.word !== 16'h1010) $display("FAIL pd1k_word: got %h expected 1010", c.word); else pass_cnt++;
        total_cnt++; if (c.nfalls !== 16) $display("FAIL pd1k_nfalls: got %0d expected 16", c.nfalls); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words = '0;
        int          nfalls = 0, done_cnt = 0, fall1 = -1, fall2 = -1;
        logic        p_sclk, p_sync;
        int          waited = 0;
        while (bus_if.ready !== 1'b1 && waited < 200) begin @(posedge clk); #1; waited++; end
        bus_if.sample = 8'h00; bus_if.pd = PD_NORMAL; bus_if.valid = 1'b1;
        @(posedge clk); #1;
        bus_if.sample = 8'hFF;
        p_sclk = bus_if.sclk; p_sync = bus_if.sync;
        for (int e = 1; e <= 140; e++) begin
            @(posedge clk); #1;
            if (e == 70) bus_if.valid = 1'b0;
            if (p_sclk && !bus_if.sclk) begin words = {words[30:0], bus_if.din}; nfalls++; end
            if (p_sync && !bus_if.sync) begin
                if (fall1 < 0) fall1 = e; else if (fall2 < 0) fall2 = e;
            end
            if (bus_if.frame_done) done_cnt++;
            p_sclk = bus_if.sclk; p_sync = bus_if.sync;
        end
        total_cnt++; if (fall1 !== 1) $display("FAIL b2b_fall1: got %0d expected 1", fall1); else pass_cnt++;
        total_cnt++; if (fall2 !== 71) $display("FAIL b2b_fall2: got %0d expected 71", fall2); else pass_cnt++;
        total_cnt++; if (nfalls !== 32) $display("FAIL b2b_nfalls: got %0d expected 32", nfalls); else pass_cnt++;
        total_cnt++; if (words !== 32'h0000_0FF0) $display("FAIL b2b_words: got %h expected 00000ff0", words); else pass_cnt++;
        total_cnt++; if (done_cnt !== 2) $display("FAIL b2b_done_cnt: got %0d expected 2", done_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        cap_t c;
        bit   ok;
        // 0xDA puts a 1 on DIN for the fifth bit period, which spans edge 19.
        do_accept(8'hDA, PD_NORMAL, ok);
        repeat (19) @(posedge clk);
        #1;
        total_cnt++; if (bus_if.sclk !== 1'b0) $display("FAIL mid_sclk_pre: got %b expected 0", bus_if.sclk); else pass_cnt++;
        total_cnt++; if (bus_if.din !== 1'b1) $display("FAIL mid_din_pre: got %b expected 1", bus_if.din); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus_if.sync !== 1'b1) $display("FAIL mid_sync: got %b expected 1", bus_if.sync); else pass_cnt++;
        total_cnt++; if (bus_if.sclk !== 1'b1) $display("FAIL mid_sclk: got %b expected 1", bus_if.sclk); else pass_cnt++;
        total_cnt++; if (bus_if.din !== 1'b0) $display("FAIL mid_din: got %b expected 0", bus_if.din); else pass_cnt++;
        total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", bus_if.busy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus_if.ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", bus_if.ready); else pass_cnt++;
        do_accept(8'hC3, PD_100K, ok);
        capture(72, c);
        total_cnt++; if (c.word !== 16'h2C30) $display("FAIL mid_word: got %h expected 2c30", c.word); else pass_cnt++;
        total_cnt++; if (c.first_fall !== 3) $display("FAIL mid_first_fall: got %0d expected 3", c.first_fall); else pass_cnt++;
        total_cnt++; if (c.sync_rise !== 67) $display("FAIL mid_sync_rise: got %0d expected 67", c.sync_rise); else pass_cnt++;
        total_cnt++; if (c.done_cnt !== 1) $display("FAIL mid_done: got %0d expected 1", c.done_cnt); else pass_cnt++;
    endtask

    task automatic test_dup();
        cap_t c;
        bit   ok;
        do_accept(8'h80, PD_NORMAL, ok);
        capture(72, c);
        total_cnt++; if (c.word !== 16'h0800) $display("FAIL dup1_word: got %h expected 0800", c.word); else pass_cnt++;
        total_cnt++; if (c.done_cnt !== 1) $display("FAIL dup1_done: got %0d expected 1", c.done_cnt); else pass_cnt++;
        do_accept(8'h80, PD_NORMAL, ok);
`ifdef DAC_TX_SKIP_DUP_EN
        total_cnt++; if (bus_if.ready !== 1'b1) $display("FAIL dup2_ready: got %b expected 1", bus_if.ready); else pass_cnt++;
        capture(72, c);
        total_cnt++; if (c.done_cnt !== 0) $display("FAIL dup2_done: got %0d expected 0", c.done_cnt); else pass_cnt++;
        total_cnt++; if (c.sync_fall !== -1) $display("FAIL dup2_sync_fall: got %0d expected -1", c.sync_fall); else pass_cnt++;
`else
        total_cnt++; if (bus_if.ready !== 1'b0) $display("FAIL dup2_ready: got %b expected 0", bus_if.ready); else pass_cnt++;
        capture(72, c);
        total_cnt++; if (c.done_cnt !== 1) $display("FAIL dup2_done: got %0d expected 1", c.done_cnt); else pass_cnt++;
        total_cnt++; if (c.word !== 16'h0800) $display("FAIL dup2_word: got %h expected 0800", c.word); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_pd_words();
        test_back_to_back();
        test_reset_mid_frame();
        test_dup();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
